// File: rtl/udp_steer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_steer_pkg
//  Description : Shared types and constants for the UDP port steering block.
//                Holds the UDP meta record, the port-table entry type and the
//                steering FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package udp_steer_pkg;

    localparam int PORT_W = 16;

    // One port-table entry: a 16-bit UDP destination port
    typedef logic [PORT_W-1:0] port_entry_t;

    // UDP message meta as delivered by the receive path
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        port_entry_t src_port;
        port_entry_t dst_port;
        logic [15:0] data_length;
    } udp_info;

    // Steering FSM state encoding
    typedef logic [1:0] steer_state_e;
    localparam steer_state_e META_WAIT  = 2'd0;
    localparam steer_state_e DATA_PASS  = 2'd1;
    localparam steer_state_e DATA_DRAIN = 2'd2;

    // Marker for "no endpoint selected" (message is drained)
    localparam logic [7:0] DST_NONE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/udp_port_match.sv
`default_nettype none
// ============================================================================
//  Module      : udp_port_match
//  Description : Combinational priority matcher. Compares a UDP port against
//                every enabled port-table entry; the lowest matching index
//                wins so duplicate entries resolve deterministically.
//  Revision    : 1.0  initial release
// ============================================================================
module udp_port_match
    import udp_steer_pkg::*;
#(
    parameter int NUM_DST = 4,
    parameter int DST_W   = 2
) (
    input  logic [NUM_DST*PORT_W-1:0] i_port_table,
    input  logic [NUM_DST-1:0]        i_port_en,
    input  port_entry_t               i_port,
    output logic                      o_hit,
    output logic [DST_W-1:0]          o_idx
);

    // Scan high to low so the last assignment comes from the lowest index
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_DST - 1; i >= 0; i--) begin
            if (i_port_en[i] && (i_port_table[i*PORT_W +: PORT_W] == i_port)) begin
                o_hit = 1'b1;
                o_idx = DST_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_port_steer.sv
`default_nettype none
// ============================================================================
//  Module      : udp_port_steer
//  Description : Steers each UDP message (one meta + data beats) to one of
//                NUM_DST endpoints by matching meta dst_port against a runtime
//                port table. Unmatched messages go to a default endpoint or
//                are drained and counted. One message in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module udp_port_steer
    import udp_steer_pkg::*;
#(
    parameter int NOC_DATA_W     = 512,
    parameter int NOC_PADBYTES_W = 6,
    parameter int NUM_DST        = 4,
    parameter int DST_W          = 2,
    parameter bit DROP_UNMATCHED = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        src_meta_val,
    input  udp_info                     src_meta_info,
    output logic                        src_meta_rdy,
    input  logic                        src_data_val,
    input  logic [NOC_DATA_W-1:0]       src_data,
    input  logic                        src_data_last,
    input  logic [NOC_PADBYTES_W-1:0]   src_data_padbytes,
    output logic                        src_data_rdy,

    output logic [NUM_DST-1:0]          dst_meta_val,
    output udp_info                     dst_meta_info,
    input  logic [NUM_DST-1:0]          dst_meta_rdy,
    output logic [NUM_DST-1:0]          dst_data_val,
    output logic [NOC_DATA_W-1:0]       dst_data,
    output logic                        dst_data_last,
    output logic [NOC_PADBYTES_W-1:0]   dst_data_padbytes,
    input  logic [NUM_DST-1:0]          dst_data_rdy,

    input  logic [NUM_DST*PORT_W-1:0]   cfg_port_table,
    input  logic [NUM_DST-1:0]          cfg_port_en,
    input  logic [DST_W-1:0]            cfg_default_dst,
    output logic [31:0]                 drop_cnt
);

    steer_state_e     r_state;
    logic [DST_W-1:0] r_sel;
    logic [31:0]      r_drop_cnt;

    logic             w_hit;
    logic [DST_W-1:0] w_hit_idx;
    logic             w_route_ok;
    logic [DST_W-1:0] w_route_idx;

    udp_port_match #(
        .NUM_DST (NUM_DST),
        .DST_W   (DST_W)
    ) u_match (
        .i_port_table (cfg_port_table),
        .i_port_en    (cfg_port_en),
        .i_port       (src_meta_info.dst_port),
        .o_hit        (w_hit),
        .o_idx        (w_hit_idx)
    );

    // Resolve the target endpoint; an out-of-range default falls back to drop
    always_comb begin
        w_route_ok  = 1'b0;
        w_route_idx = '0;
        if (w_hit) begin
            w_route_ok  = 1'b1;
            w_route_idx = w_hit_idx;
        end else if (!DROP_UNMATCHED && (32'(cfg_default_dst) < NUM_DST)) begin
            w_route_ok  = 1'b1;
            w_route_idx = cfg_default_dst;
        end
    end

    // Per-endpoint valid demux and ready mux; valids never depend on readies
    always_comb begin
        dst_meta_val = '0;
        dst_data_val = '0;
        src_meta_rdy = 1'b0;
        src_data_rdy = 1'b0;
        case (r_state)
            META_WAIT: begin
                if (w_route_ok) begin
                    dst_meta_val[w_route_idx] = src_meta_val;
                    src_meta_rdy              = dst_meta_rdy[w_route_idx];
                end else begin
                    src_meta_rdy = 1'b1;
                end
            end
            DATA_PASS: begin
                dst_data_val[r_sel] = src_data_val;
                src_data_rdy        = dst_data_rdy[r_sel];
            end
            DATA_DRAIN: begin
                src_data_rdy = 1'b1;
            end
            default: begin
                src_data_rdy = 1'b0;
            end
        endcase
        // Handshakes are held off while reset is applied
        if (rst) begin
            dst_meta_val = '0;
            dst_data_val = '0;
            src_meta_rdy = 1'b0;
            src_data_rdy = 1'b0;
        end
    end

    // Meta and data fields are broadcast to every endpoint
    assign dst_meta_info     = src_meta_info;
    assign dst_data          = src_data;
    assign dst_data_last     = src_data_last;
    assign dst_data_padbytes = src_data_padbytes;
    assign drop_cnt          = r_drop_cnt;

    // Message FSM: latch the route at meta accept, release on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= META_WAIT;
            r_sel      <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                META_WAIT: begin
                    if (src_meta_val && src_meta_rdy) begin
                        r_sel   <= w_route_idx;
                        r_state <= w_route_ok ? DATA_PASS : DATA_DRAIN;
                    end
                end
                DATA_PASS: begin
                    if (src_data_val && src_data_rdy && src_data_last) begin
                        r_state <= META_WAIT;
                    end
                end
                DATA_DRAIN: begin
                    if (src_data_val && src_data_last) begin
                        r_state <= META_WAIT;
                        if (r_drop_cnt != 32'hFFFF_FFFF) begin
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state <= META_WAIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_port_steer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_port_steer
//  Description : Directed self-checking bench for udp_port_steer. Instance a
//                drains unmatched messages, instance b sends them to the
//                default endpoint; use_nd picks which one sees valids.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_udp_port_steer;
    import udp_steer_pkg::*;

    localparam int DW  = 512;
    localparam int PW  = 6;
    localparam int ND  = 4;
    localparam int DSW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              use_nd;
    logic              src_meta_val;
    udp_info           src_meta_info;
    logic              src_data_val;
    logic [DW-1:0]     src_data;
    logic              src_data_last;
    logic [PW-1:0]     src_data_padbytes;
    logic [ND-1:0]     dst_meta_rdy;
    logic [ND-1:0]     dst_data_rdy;
    logic [ND*16-1:0]  cfg_port_table;
    logic [ND-1:0]     cfg_port_en;
    logic [DSW-1:0]    cfg_default_dst;

    logic a_mval, a_dval, b_mval, b_dval;
    assign a_mval = src_meta_val & ~use_nd;
    assign a_dval = src_data_val & ~use_nd;
    assign b_mval = src_meta_val &  use_nd;
    assign b_dval = src_data_val &  use_nd;

    logic a_src_meta_rdy, a_src_data_rdy, a_dst_data_last;
    logic [ND-1:0] a_dst_meta_val, a_dst_data_val;
    udp_info a_dst_meta_info;
    logic [DW-1:0] a_dst_data;
    logic [PW-1:0] a_dst_data_padbytes;
    logic [31:0] a_drop_cnt;

    logic b_src_meta_rdy, b_src_data_rdy, b_dst_data_last;
    logic [ND-1:0] b_dst_meta_val, b_dst_data_val;
    udp_info b_dst_meta_info;
    logic [DW-1:0] b_dst_data;
    logic [PW-1:0] b_dst_data_padbytes;
    logic [31:0] b_drop_cnt;

    udp_port_steer #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .NUM_DST(ND), .DST_W(DSW),
                     .DROP_UNMATCHED(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .src_meta_val(a_mval), .src_meta_info(src_meta_info), .src_meta_rdy(a_src_meta_rdy),
        .src_data_val(a_dval), .src_data(src_data), .src_data_last(src_data_last),
        .src_data_padbytes(src_data_padbytes), .src_data_rdy(a_src_data_rdy),
        .dst_meta_val(a_dst_meta_val), .dst_meta_info(a_dst_meta_info), .dst_meta_rdy(dst_meta_rdy),
        .dst_data_val(a_dst_data_val), .dst_data(a_dst_data), .dst_data_last(a_dst_data_last),
        .dst_data_padbytes(a_dst_data_padbytes), .dst_data_rdy(dst_data_rdy),
        .cfg_port_table(cfg_port_table), .cfg_port_en(cfg_port_en),
        .cfg_default_dst(cfg_default_dst), .drop_cnt(a_drop_cnt)
    );

    udp_port_steer #(.NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .NUM_DST(ND), .DST_W(DSW),
                     .DROP_UNMATCHED(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .src_meta_val(b_mval), .src_meta_info(src_meta_info), .src_meta_rdy(b_src_meta_rdy),
        .src_data_val(b_dval), .src_data(src_data), .src_data_last(src_data_last),
        .src_data_padbytes(src_data_padbytes), .src_data_rdy(b_src_data_rdy),
        .dst_meta_val(b_dst_meta_val), .dst_meta_info(b_dst_meta_info), .dst_meta_rdy(dst_meta_rdy),
        .dst_data_val(b_dst_data_val), .dst_data(b_dst_data), .dst_data_last(b_dst_data_last),
        .dst_data_padbytes(b_dst_data_padbytes), .dst_data_rdy(dst_data_rdy),
        .cfg_port_table(cfg_port_table), .cfg_port_en(cfg_port_en),
        .cfg_default_dst(cfg_default_dst), .drop_cnt(b_drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_meta_val = 1'b1;
        src_meta_info.dst_port = 16'd9999;
        src_data_val = 1'b1;
        tick();
        tick();
        checks++;
        if (a_src_meta_rdy !== 1'b0) begin errors++; $display("FAIL reset_meta_rdy got=%b want=0", a_src_meta_rdy); end
        checks++;
        if (a_src_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_data_rdy got=%b want=0", a_src_data_rdy); end
        checks++;
        if (a_dst_meta_val !== 4'b0000 || a_dst_data_val !== 4'b0000) begin
            errors++; $display("FAIL reset_vals got meta=%b data=%b want 0000", a_dst_meta_val, a_dst_data_val);
        end
        checks++;
        if (a_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d want=0", a_drop_cnt); end
        rst = 1'b0;
        src_meta_val = 1'b0;
        src_data_val = 1'b0;
        tick();
    endtask

    task automatic test_route();
        src_meta_info.dst_port = 16'd7002;
        src_meta_val = 1'b1;
        src_data_val = 1'b1;
        src_data = DW'(100);
        src_data_last = 1'b0;
        #1;
        checks++;
        if (a_dst_meta_val !== 4'b0100 || a_src_meta_rdy !== 1'b1) begin
            errors++; $display("FAIL route_meta got val=%b rdy=%b want 0100/1", a_dst_meta_val, a_src_meta_rdy);
        end
        checks++;
        if (a_src_data_rdy !== 1'b0 || a_dst_data_val !== 4'b0000) begin
            errors++; $display("FAIL route_no_data_in_meta got rdy=%b val=%b want 0/0000", a_src_data_rdy, a_dst_data_val);
        end
        checks++;
        if (a_dst_meta_info.dst_port !== 16'd7002) begin
            errors++; $display("FAIL route_meta_info got=%0d want=7002", a_dst_meta_info.dst_port);
        end
        tick();
        src_meta_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            src_data = DW'(100 + k);
            src_data_last = (k == 2);
            src_data_padbytes = (k == 2) ? 6'd5 : 6'd0;
            #1;
            checks++;
            if (a_dst_data_val !== 4'b0100 || a_src_data_rdy !== 1'b1 || a_dst_meta_val !== 4'b0000) begin
                errors++; $display("FAIL route_beat%0d got val=%b rdy=%b meta=%b want 0100/1/0000",
                                   k, a_dst_data_val, a_src_data_rdy, a_dst_meta_val);
            end
            checks++;
            if (a_dst_data[15:0] !== 16'(100 + k) || a_dst_data_last !== (k == 2) ||
                a_dst_data_padbytes !== ((k == 2) ? 6'd5 : 6'd0)) begin
                errors++; $display("FAIL route_fields%0d got data=%0d last=%b pad=%0d want %0d/%b",
                                   k, a_dst_data[15:0], a_dst_data_last, a_dst_data_padbytes, 100 + k, (k == 2));
            end
            tick();
        end
        #1;
        checks++;
        if (a_src_data_rdy !== 1'b0 || a_dst_data_val !== 4'b0000) begin
            errors++; $display("FAIL route_back_to_meta got rdy=%b val=%b want 0/0000", a_src_data_rdy, a_dst_data_val);
        end
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        src_meta_info.dst_port = 16'd9999;
        src_meta_val = 1'b1;
        #1;
        checks++;
        if (a_dst_meta_val !== 4'b0000 || a_src_meta_rdy !== 1'b1 || a_drop_cnt !== 32'd0) begin
            errors++; $display("FAIL drop_meta got val=%b rdy=%b cnt=%0d want 0000/1/0",
                               a_dst_meta_val, a_src_meta_rdy, a_drop_cnt);
        end
        tick();
        src_meta_val = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_data_val = 1'b1;
            src_data = DW'(300 + k);
            src_data_last = (k == 1);
            #1;
            checks++;
            if (a_src_data_rdy !== 1'b1 || a_dst_data_val !== 4'b0000) begin
                errors++; $display("FAIL drop_beat%0d got rdy=%b val=%b want 1/0000", k, a_src_data_rdy, a_dst_data_val);
            end
            tick();
        end
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        #1;
        checks++;
        if (a_drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt got=%0d want=1", a_drop_cnt); end
        tick();
    endtask

    task automatic test_default();
        use_nd = 1'b1;
        cfg_default_dst = 2'd1;
        src_meta_info.dst_port = 16'd9999;
        src_meta_val = 1'b1;
        #1;
        checks++;
        if (b_dst_meta_val !== 4'b0010 || b_src_meta_rdy !== 1'b1) begin
            errors++; $display("FAIL default_meta got val=%b rdy=%b want 0010/1", b_dst_meta_val, b_src_meta_rdy);
        end
        tick();
        src_meta_val = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_data_val = 1'b1;
            src_data = DW'(400 + k);
            src_data_last = (k == 1);
            #1;
            checks++;
            if (b_dst_data_val !== 4'b0010 || b_dst_data[15:0] !== 16'(400 + k)) begin
                errors++; $display("FAIL default_beat%0d got val=%b data=%0d want 0010/%0d",
                                   k, b_dst_data_val, b_dst_data[15:0], 400 + k);
            end
            tick();
        end
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        #1;
        checks++;
        if (b_drop_cnt !== 32'd0) begin errors++; $display("FAIL default_drop_cnt got=%0d want=0", b_drop_cnt); end
        use_nd = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int rx[$];
        int bad = 0;
        int k = 0;
        int budget = 0;
        src_meta_info.dst_port = 16'd7000;
        src_meta_val = 1'b1;
        tick();
        src_meta_val = 1'b0;
        src_data_val = 1'b1;
        while (k < 6 && budget < 300) begin
            src_data = DW'(200 + k);
            src_data_last = (k == 5);
            dst_data_rdy = {3'b111, ($urandom_range(0, 9) < 3)};
            #1;
            if (a_dst_data_val !== 4'b0001) bad++;
            if (a_src_data_rdy === 1'b1) begin
                rx.push_back(int'(a_dst_data[15:0]));
                k++;
            end
            tick();
            budget++;
        end
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        dst_data_rdy = 4'b1111;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_valid_onehot got=%0d bad cycles want=0", bad); end
        checks++;
        if (rx.size() != 6) begin errors++; $display("FAIL bp_count got=%0d want=6", rx.size()); end
        for (int i = 0; i < rx.size(); i++) begin
            checks++;
            if (rx[i] != 200 + i) begin errors++; $display("FAIL bp_order%0d got=%0d want=%0d", i, rx[i], 200 + i); end
        end
        tick();
    endtask

    task automatic test_dup_toggle();
        cfg_port_table[3*16 +: 16] = 16'd7000;
        src_meta_info.dst_port = 16'd7000;
        src_meta_val = 1'b1;
        #1;
        checks++;
        if (a_dst_meta_val !== 4'b0001) begin errors++; $display("FAIL dup_lowest got=%b want=0001", a_dst_meta_val); end
        tick();
        src_meta_val = 1'b0;
        cfg_port_en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            src_data_val = 1'b1;
            src_data = DW'(500 + k);
            src_data_last = (k == 2);
            #1;
            checks++;
            if (a_dst_data_val !== 4'b0001) begin
                errors++; $display("FAIL dup_latched_beat%0d got=%b want=0001", k, a_dst_data_val);
            end
            tick();
        end
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        src_meta_val = 1'b1;
        #1;
        checks++;
        if (a_dst_meta_val !== 4'b1000) begin errors++; $display("FAIL dup_after_disable got=%b want=1000", a_dst_meta_val); end
        src_meta_val = 1'b0;
        cfg_port_en[0] = 1'b1;
        cfg_port_table[3*16 +: 16] = 16'd7003;
        tick();
    endtask

    task automatic test_rst_mid();
        src_meta_info.dst_port = 16'd7001;
        src_meta_val = 1'b1;
        tick();
        src_meta_val = 1'b0;
        src_data_val = 1'b1;
        src_data = DW'(600);
        src_data_last = 1'b0;
        tick();
        src_data = DW'(601);
        rst = 1'b1;
        #1;
        checks++;
        if (a_dst_data_val !== 4'b0000 || a_src_data_rdy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_during got val=%b rdy=%b want 0000/0", a_dst_data_val, a_src_data_rdy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (a_dst_data_val !== 4'b0000 || a_src_data_rdy !== 1'b0 || a_drop_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_mid_after got val=%b rdy=%b cnt=%0d want 0000/0/0",
                               a_dst_data_val, a_src_data_rdy, a_drop_cnt);
        end
        src_data_val = 1'b0;
        tick();
        src_meta_info.dst_port = 16'd7003;
        src_meta_val = 1'b1;
        #1;
        checks++;
        if (a_dst_meta_val !== 4'b1000 || a_src_meta_rdy !== 1'b1) begin
            errors++; $display("FAIL rst_fresh_meta got val=%b rdy=%b want 1000/1", a_dst_meta_val, a_src_meta_rdy);
        end
        tick();
        src_meta_val = 1'b0;
        src_data_val = 1'b1;
        src_data = DW'(700);
        src_data_last = 1'b1;
        #1;
        checks++;
        if (a_dst_data_val !== 4'b1000 || a_dst_data[15:0] !== 16'd700 || a_dst_data_last !== 1'b1) begin
            errors++; $display("FAIL rst_fresh_beat got val=%b data=%0d last=%b want 1000/700/1",
                               a_dst_data_val, a_dst_data[15:0], a_dst_data_last);
        end
        tick();
        src_data_val = 1'b0;
        src_data_last = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        use_nd = 1'b0;
        src_meta_val = 1'b0;
        src_meta_info = '0;
        src_meta_info.src_ip = 32'h0A00_0001;
        src_meta_info.dst_ip = 32'h0A00_0002;
        src_meta_info.src_port = 16'd1234;
        src_data_val = 1'b0;
        src_data = '0;
        src_data_last = 1'b0;
        src_data_padbytes = '0;
        dst_meta_rdy = 4'b1111;
        dst_data_rdy = 4'b1111;
        cfg_port_table = {16'd7003, 16'd7002, 16'd7001, 16'd7000};
        cfg_port_en = 4'b1111;
        cfg_default_dst = 2'd0;

        test_reset();
        test_route();
        test_drop();
        test_default();
        test_backpressure();
        test_dup_toggle();
        test_rst_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
